grid_scan_driver: RTL and testbench
===================================

GRID_SCAN_DRIVER -- requirements
Module: grid_scan_driver

Interface
REQ-001 Parameter DWELL, default 1000: clock cycles each row is driven; legal range >= 1.
REQ-002 Parameter BLANK, default 16: clock cycles of all-off blanking before each row; legal range >= 1.
REQ-003 clka  input  1  sole clock; all logic on negedge clka, matching the life datapath.
REQ-004 stop  input  1  reset, synchronous, active-high.
REQ-005 grid  input  49  generation from life datapath; cell (r,c) = grid[7*r+c], r,c in 0..6.
REQ-006 grid_load  input  1  one-cycle request to capture grid.
REQ-007 row_sel  output  7  one-hot row drive, active-high; bit r = row r.
REQ-008 col_data  output  7  column drive for the selected row; bit c = cell (row,c).
REQ-009 frame_start  output  1  one-cycle pulse marking the frame boundary.
REQ-010 load_ack  output  1  one-cycle pulse: pending grid is now displayed.
REQ-011 pop_count  output  6  live-cell count of the displayed grid, 0..49.

Function
REQ-012 Registers: pend (49b) plus pend_valid; disp (49b) drives the LEDs; scan state, row (3b), dwell counter of width clog2(max(DWELL,BLANK)).
REQ-013 Scan FSM has two states, BLANK and DRIVE; BLANK lasts exactly BLANK cycles with row_sel=0 and col_data=0.
REQ-014 DRIVE lasts exactly DWELL cycles with row_sel=1<<row and col_data=disp[7*row+6 : 7*row].
REQ-015 DRIVE end -> BLANK with row incremented; row 6 wraps to 0; frame period = 7*(BLANK+DWELL) cycles.
REQ-016 Frame boundary = first BLANK cycle of row 0; frame_start is high exactly that cycle.
REQ-017 grid_load=1 -> pend<=grid and pend_valid<=1 next edge; repeated loads before a boundary overwrite pend (latest wins).
REQ-018 At a boundary with pend_valid=1: disp<=pend, pend_valid<=0, load_ack high the following cycle.
REQ-019 At a boundary with pend_valid=0: disp unchanged, no load_ack.
REQ-020 grid_load on a boundary cycle: the boundary transfers the pend value held before that edge; the new grid lands in pend with pend_valid=1, shown next frame.
REQ-021 disp never changes mid-frame; no row displays a mix of two generations.
REQ-022 pop_count is registered: equals popcount(disp) from the cycle after disp changes (same cycle as load_ack is high, value of new disp).
REQ-023 Inputs are sampled only on the active edge; grid need be stable only in the grid_load cycle.

Reset
REQ-024 While stop=1: state BLANK, row 0, counter 0, disp 0, pend 0, pend_valid 0, pop_count 0, all outputs 0.
REQ-025 First cycle after stop deasserts is a frame boundary: frame_start=1, with row_sel=0.
REQ-026 stop mid-frame or mid-load aborts immediately; pending grid discarded, no load_ack.

Structure
REQ-027 Shared package game_of_life_pkg holds GRID_N=7, GRID_CELLS=49, and the scan state enum.
REQ-028 One sub-module grid_popcount (49-bit in, 6-bit out, combinational) feeds the pop_count register.
REQ-029 No other sub-modules.

Verification (DWELL=4, BLANK=2, period 42)
REQ-030 Release stop, no loads -> frame_start at cycles 0,42,84; row_sel cycles 0,0,01,01,01,01,0,0,02,...,40; col_data always 0.
REQ-031 grid=49'h1_0000_0000_0001 (cells 0,48), load at cycle 5 -> load_ack at 43, pop_count=2 at 43; row0 col_data=01 cycles 44-47; row6 col_data=40 cycles 80-83.
REQ-032 Loads at cycles 10 (all ones) and 20 (grid=7F in row 3 only) -> one load_ack at 43; pop_count=7; only row 3 lit.
REQ-033 Load all-ones exactly on cycle 42 -> frame 42-83 dark, no ack at 43; ack at 85, pop_count=49, every row col_data=7F.
REQ-034 Load at cycle 5, stop=1 at cycle 30 for 3 cycles -> no load_ack ever, outputs 0 during stop, frame_start first cycle after release, display dark.
REQ-035 Checker: row_sel always zero or one-hot, and col_data=0 whenever row_sel=0.

Source files
------------

// File: rtl/game_of_life_pkg.sv
// Shared constants and scan-state type for the life display path.
// The helper sizes the scan counter so it can hold the longer of the two phases.
package game_of_life_pkg;
  localparam int GRID_N     = 7;
  localparam int GRID_CELLS = GRID_N * GRID_N;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/grid_popcount.sv
// Combinational live-cell counter for one 7x7 generation (result 0..49).
module grid_popcount
  import game_of_life_pkg::*;
(
  input  logic [GRID_CELLS-1:0] cells,
  output logic [5:0]            count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < GRID_CELLS; i++) begin
      count = count + 6'(cells[i]);
    end
  end
endmodule

// File: rtl/grid_scan_driver.sv
// Row-multiplexed LED scan of a double-buffered 7x7 life grid, clocked on negedge clka.
// A new grid waits in pend and is swapped into disp only at a frame boundary.
module grid_scan_driver
  import game_of_life_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 16
) (
  input  logic        clka,
  input  logic        stop,
  input  logic [48:0] grid,
  input  logic        grid_load,
  output logic [6:0]  row_sel,
  output logic [6:0]  col_data,
  output logic        frame_start,
  output logic        load_ack,
  output logic [5:0]  pop_count,
  output logic        scan_state
);
  localparam int CW = cnt_width(DWELL, BLANK);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  scan_state_t   state, state_nx;
  logic [2:0]    row, row_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [48:0]   pend, disp;
  logic          pend_valid;
  logic [5:0]    pend_pop;
  logic          boundary;
  logic [6:0]    disp_rows [GRID_N];

  // Handshake: grid_load is a one-cycle request with no ready; the driver
  // always accepts it, the latest request before a boundary wins, and
  // load_ack pulses the cycle after that pend value becomes the display.
  assign boundary = (state == ST_BLANK) && (row == 3'd0) && (cnt == '0);

  grid_popcount u_popcount (
    .cells (pend),
    .count (pend_pop)
  );

  always_comb begin
    state_nx = state;
    row_nx   = row;
    cnt_nx   = cnt + CW'(1);
    unique case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = ST_DRIVE;
          cnt_nx   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt == DWELL_LAST) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
          row_nx   = (row == 3'd6) ? 3'd0 : row + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge clka) begin
    if (stop) begin
      state      <= ST_BLANK;
      row        <= 3'd0;
      cnt        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      disp       <= '0;
      pop_count  <= '0;
      load_ack   <= 1'b0;
    end else begin
      state    <= state_nx;
      row      <= row_nx;
      cnt      <= cnt_nx;
      load_ack <= boundary && pend_valid;
      if (boundary && pend_valid) begin
        disp      <= pend;
        pop_count <= pend_pop;
      end
      // A load on the boundary edge refills pend after the old value moved out.
      if (grid_load) begin
        pend       <= grid;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

  for (genvar r = 0; r < GRID_N; r++) begin : g_rows
    assign disp_rows[r] = disp[GRID_N*r +: GRID_N];
  end

  always_comb begin
    row_sel  = '0;
    col_data = '0;
    if (state == ST_DRIVE) begin
      row_sel  = 7'b1 << row;
      col_data = disp_rows[row];
    end
  end

  // Reset state looks like a boundary, so the pulse is held off while stop is high.
  assign frame_start = boundary && !stop;
  assign scan_state  = (state == ST_DRIVE);
endmodule

// File: tb/tb_grid_scan_driver.sv
// Directed bench for grid_scan_driver with DWELL=4, BLANK=2 (frame period 42).
// Cycle 0 is the first cycle after stop is released; outputs are sampled on posedge.
module tb_grid_scan_driver;
  logic        clka;
  logic        stop;
  logic [48:0] grid;
  logic        grid_load;
  logic [6:0]  row_sel;
  logic [6:0]  col_data;
  logic        frame_start;
  logic        load_ack;
  logic [5:0]  pop_count;
  logic        scan_state;

  int n_cmp;
  int n_bad;

  logic [6:0] rs_a [200];
  logic [6:0] cd_a [200];
  logic       fs_a [200];
  logic       la_a [200];
  logic [5:0] pc_a [200];

  grid_scan_driver #(.DWELL(4), .BLANK(2)) dut (
    .clka        (clka),
    .stop        (stop),
    .grid        (grid),
    .grid_load   (grid_load),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .load_ack    (load_ack),
    .pop_count   (pop_count),
    .scan_state  (scan_state)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  function automatic logic [6:0] exp_rsel(input int t);
    int p;
    p = t % 42;
    return ((p % 6) >= 2) ? 7'(1 << (p / 6)) : 7'h00;
  endfunction

  function automatic int exp_row(input int t);
    return (t % 42) / 6;
  endfunction

  task automatic release_stop();
    grid_load = 1'b0;
    stop      = 1'b1;
    repeat (3) @(negedge clka);
    #1;
    stop = 1'b0;
  endtask

  // Drives loads/stop per cycle index and records outputs; called at the start of cycle 0.
  task automatic run_cycles(input int n, input int l0c, input logic [48:0] l0g,
                            input int l1c, input logic [48:0] l1g,
                            input int s_from, input int s_len);
    for (int cyc = 0; cyc < n; cyc++) begin
      grid_load = 1'b0;
      grid      = '0;
      if (cyc == l0c) begin grid_load = 1'b1; grid = l0g; end
      if (cyc == l1c) begin grid_load = 1'b1; grid = l1g; end
      stop = (cyc >= s_from) && (cyc < s_from + s_len);
      @(posedge clka);
      rs_a[cyc] = row_sel;
      cd_a[cyc] = col_data;
      fs_a[cyc] = frame_start;
      la_a[cyc] = load_ack;
      pc_a[cyc] = pop_count;
      @(negedge clka);
      #1;
    end
    grid_load = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic test_reset();
    stop      = 1'b1;
    grid_load = 1'b1;
    grid      = '1;
    repeat (3) @(negedge clka);
    @(posedge clka);
    n_cmp += 6;
    if (row_sel !== 7'h00) begin n_bad++; $display("FAIL reset_row_sel got=%h exp=00", row_sel); end
    if (col_data !== 7'h00) begin n_bad++; $display("FAIL reset_col_data got=%h exp=00", col_data); end
    if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    if (load_ack !== 1'b0) begin n_bad++; $display("FAIL reset_load_ack got=%b exp=0", load_ack); end
    if (pop_count !== 6'd0) begin n_bad++; $display("FAIL reset_pop_count got=%0d exp=0", pop_count); end
    if (scan_state !== 1'b0) begin n_bad++; $display("FAIL reset_scan_state got=%b exp=0", scan_state); end
    grid_load = 1'b0;
    @(negedge clka);
    #1;
  endtask

  task automatic test_idle_scan();
    logic [6:0] r;
    release_stop();
    run_cycles(90, -1, '0, -1, '0, -1, 0);
    for (int t = 0; t < 90; t++) begin
      n_cmp += 4;
      if (fs_a[t] !== (t % 42 == 0)) begin n_bad++; $display("FAIL idle_frame_start t=%0d got=%b exp=%b", t, fs_a[t], (t % 42 == 0)); end
      if (rs_a[t] !== exp_rsel(t)) begin n_bad++; $display("FAIL idle_row_sel t=%0d got=%h exp=%h", t, rs_a[t], exp_rsel(t)); end
      if (cd_a[t] !== 7'h00) begin n_bad++; $display("FAIL idle_col_data t=%0d got=%h exp=00", t, cd_a[t]); end
      r = rs_a[t];
      if ((r & (r - 7'd1)) !== 7'h00) begin n_bad++; $display("FAIL idle_onehot t=%0d got=%h exp=onehot_or_zero", t, r); end
    end
  endtask

  task automatic test_single_load();
    logic [6:0] exp_cd;
    release_stop();
    run_cycles(90, 5, 49'h1_0000_0000_0001, -1, '0, -1, 0);
    for (int t = 0; t < 90; t++) begin
      exp_cd = 7'h00;
      if (t >= 44 && exp_rsel(t) != 7'h00) begin
        if (exp_row(t) == 0) exp_cd = 7'h01;
        if (exp_row(t) == 6) exp_cd = 7'h40;
      end
      n_cmp += 3;
      if (la_a[t] !== (t == 43)) begin n_bad++; $display("FAIL single_load_ack t=%0d got=%b exp=%b", t, la_a[t], (t == 43)); end
      if (pc_a[t] !== ((t >= 43) ? 6'd2 : 6'd0)) begin n_bad++; $display("FAIL single_pop_count t=%0d got=%0d exp=%0d", t, pc_a[t], (t >= 43) ? 2 : 0); end
      if (cd_a[t] !== exp_cd) begin n_bad++; $display("FAIL single_col_data t=%0d got=%h exp=%h", t, cd_a[t], exp_cd); end
      if (rs_a[t] == 7'h00 && cd_a[t] != 7'h00) begin n_bad++; $display("FAIL single_dark_cols t=%0d got=%h exp=00", t, cd_a[t]); end
      n_cmp++;
    end
  endtask

  task automatic test_overwrite();
    logic [6:0] exp_cd;
    release_stop();
    run_cycles(90, 10, '1, 20, 49'h7F << 21, -1, 0);
    for (int t = 0; t < 90; t++) begin
      exp_cd = (t >= 44 && exp_rsel(t) != 7'h00 && exp_row(t) == 3) ? 7'h7F : 7'h00;
      n_cmp += 3;
      if (la_a[t] !== (t == 43)) begin n_bad++; $display("FAIL overwrite_load_ack t=%0d got=%b exp=%b", t, la_a[t], (t == 43)); end
      if (pc_a[t] !== ((t >= 43) ? 6'd7 : 6'd0)) begin n_bad++; $display("FAIL overwrite_pop_count t=%0d got=%0d exp=%0d", t, pc_a[t], (t >= 43) ? 7 : 0); end
      if (cd_a[t] !== exp_cd) begin n_bad++; $display("FAIL overwrite_col_data t=%0d got=%h exp=%h", t, cd_a[t], exp_cd); end
    end
  endtask

  task automatic test_boundary_load();
    logic [6:0] exp_cd;
    release_stop();
    run_cycles(130, 42, '1, -1, '0, -1, 0);
    for (int t = 0; t < 130; t++) begin
      exp_cd = (t >= 86 && exp_rsel(t) != 7'h00) ? 7'h7F : 7'h00;
      n_cmp += 4;
      if (la_a[t] !== (t == 85)) begin n_bad++; $display("FAIL boundary_load_ack t=%0d got=%b exp=%b", t, la_a[t], (t == 85)); end
      if (pc_a[t] !== ((t >= 85) ? 6'd49 : 6'd0)) begin n_bad++; $display("FAIL boundary_pop_count t=%0d got=%0d exp=%0d", t, pc_a[t], (t >= 85) ? 49 : 0); end
      if (cd_a[t] !== exp_cd) begin n_bad++; $display("FAIL boundary_col_data t=%0d got=%h exp=%h", t, cd_a[t], exp_cd); end
      if (rs_a[t] !== exp_rsel(t)) begin n_bad++; $display("FAIL boundary_row_sel t=%0d got=%h exp=%h", t, rs_a[t], exp_rsel(t)); end
    end
  endtask

  task automatic test_stop_abort();
    logic       exp_fs;
    logic [6:0] exp_rs;
    release_stop();
    run_cycles(120, 5, '1, -1, '0, 30, 3);
    for (int t = 0; t < 120; t++) begin
      exp_fs = (t == 0) || (t == 33) || (t == 75) || (t == 117);
      if (t >= 33)      exp_rs = exp_rsel(t - 33);
      else if (t >= 30) exp_rs = 7'h00;
      else              exp_rs = exp_rsel(t);
      n_cmp += 5;
      if (la_a[t] !== 1'b0) begin n_bad++; $display("FAIL abort_load_ack t=%0d got=%b exp=0", t, la_a[t]); end
      if (pc_a[t] !== 6'd0) begin n_bad++; $display("FAIL abort_pop_count t=%0d got=%0d exp=0", t, pc_a[t]); end
      if (cd_a[t] !== 7'h00) begin n_bad++; $display("FAIL abort_col_data t=%0d got=%h exp=00", t, cd_a[t]); end
      if (fs_a[t] !== exp_fs) begin n_bad++; $display("FAIL abort_frame_start t=%0d got=%b exp=%b", t, fs_a[t], exp_fs); end
      if (rs_a[t] !== exp_rs) begin n_bad++; $display("FAIL abort_row_sel t=%0d got=%h exp=%h", t, rs_a[t], exp_rs); end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_cd;
    release_stop();
    run_cycles(130, 5, '1, 50, 49'h1, -1, 0);
    for (int t = 0; t < 130; t++) begin
      exp_cd = 7'h00;
      if (exp_rsel(t) != 7'h00) begin
        if (t >= 44 && t < 84) exp_cd = 7'h7F;
        if (t >= 86 && exp_row(t) == 0) exp_cd = 7'h01;
      end
      n_cmp += 3;
      if (la_a[t] !== (t == 43 || t == 85)) begin n_bad++; $display("FAIL b2b_load_ack t=%0d got=%b exp=%b", t, la_a[t], (t == 43 || t == 85)); end
      if (pc_a[t] !== ((t >= 85) ? 6'd1 : (t >= 43) ? 6'd49 : 6'd0)) begin
        n_bad++;
        $display("FAIL b2b_pop_count t=%0d got=%0d exp=%0d", t, pc_a[t], (t >= 85) ? 1 : (t >= 43) ? 49 : 0);
      end
      if (cd_a[t] !== exp_cd) begin n_bad++; $display("FAIL b2b_col_data t=%0d got=%h exp=%h", t, cd_a[t], exp_cd); end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    stop      = 1'b1;
    grid      = '0;
    grid_load = 1'b0;
    test_reset();
    test_idle_scan();
    test_single_load();
    test_overwrite();
    test_boundary_load();
    test_stop_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
